// File: rtl/mul_div_unit_if.sv
// Handshake and result bus between the pipeline (master) and mul_div_unit (slave).
interface mul_div_unit_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operand_a;
  logic [31:0] operand_b;
  logic        flush;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  modport master (
    output start, op, operand_a, operand_b, flush, hi_we, lo_we, wdata,
    input  hi, lo, busy, done, div_zero
  );

  modport slave (
    input  start, op, operand_a, operand_b, flush, hi_we, lo_we, wdata,
    output hi, lo, busy, done, div_zero
  );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit (32-cycle shift-add / restoring divide).
// Define MULDIV_FAST_MUL_EN for a single-cycle multiply; divide timing is unaffected.
module mul_div_unit (
  input  logic          clk,
  input  logic          rst_n,
  mul_div_unit_if.slave bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_SIGN = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        dz_q, dz_d;
  logic        dzp_q, dzp_d;
  logic        skip_q, skip_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic [63:0] acc_q, acc_d;
  logic [31:0] bmag_q, bmag_d;
  logic        isdiv_q, isdiv_d;
  logic        neg_lo_q, neg_lo_d;
  logic        neg_hi_q, neg_hi_d;

  function automatic logic [31:0] mag32(input logic signed [31:0] v, input logic sgn);
    return (sgn && (v < 0)) ? 32'(-v) : 32'(v);
  endfunction

  function automatic logic [31:0] sign32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] sign64(input logic [63:0] v, input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

  logic        signed_in, is_div_in, a_neg, b_neg, dz_in, fast_in;
  logic [31:0] a_mag, b_mag;
  logic [63:0] fast_prod;

  assign is_div_in = bus.op[1];
  assign signed_in = ~bus.op[0];
  assign a_neg     = signed_in & bus.operand_a[31];
  assign b_neg     = signed_in & bus.operand_b[31];
  assign a_mag     = mag32($signed(bus.operand_a), signed_in);
  assign b_mag     = mag32($signed(bus.operand_b), signed_in);
  assign dz_in     = is_div_in && (bus.operand_b == 32'd0);

`ifdef MULDIV_FAST_MUL_EN
  logic signed [63:0] fa_s, fb_s;
  assign fa_s      = $signed({{32{a_neg}}, bus.operand_a});
  assign fb_s      = $signed({{32{b_neg}}, bus.operand_b});
  assign fast_prod = 64'(fa_s * fb_s);
  assign fast_in   = ~is_div_in;
`else
  assign fast_prod = 64'd0;
  assign fast_in   = 1'b0;
`endif

  // One iteration step: acc holds {partial product, multiplier} or {remainder, quotient}.
  logic [32:0] mul_sum;
  logic        div_ge;
  logic [31:0] div_sub;
  logic [63:0] step_mul, step_div;

  assign mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, bmag_q} : 33'd0);
  assign step_mul = {mul_sum, acc_q[31:1]};
  assign div_ge   = acc_q[63:31] >= {1'b0, bmag_q};
  assign div_sub  = acc_q[62:31] - bmag_q;
  assign step_div = div_ge ? {div_sub, acc_q[30:0], 1'b1} : {acc_q[62:0], 1'b0};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dz_d     = 1'b0;
    dzp_d    = dzp_q;
    skip_d   = skip_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_d    = acc_q;
    bmag_d   = bmag_q;
    isdiv_d  = isdiv_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          acc_d    = {32'd0, a_mag};
          bmag_d   = b_mag;
          isdiv_d  = is_div_in;
          neg_lo_d = a_neg ^ b_neg;
          neg_hi_d = a_neg;
          cnt_d    = 5'd0;
          busy_d   = 1'b1;
          dzp_d    = dz_in;
          skip_d   = dz_in | fast_in;
          if (dz_in) begin
            state_d = S_SIGN;
          end else if (fast_in) begin
            {hi_d, lo_d} = fast_prod;
            state_d      = S_SIGN;
          end else begin
            state_d = S_CALC;
          end
        end else begin
          if (bus.hi_we) hi_d = bus.wdata;
          if (bus.lo_we) lo_d = bus.wdata;
        end
      end
      S_CALC: begin
        if (bus.flush) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          acc_d = isdiv_q ? step_div : step_mul;
          cnt_d = cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_d = S_SIGN;
        end
      end
      S_SIGN: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (!bus.flush) begin
          done_d = 1'b1;
          dz_d   = dzp_q;
          if (!skip_q) begin
            if (isdiv_q) begin
              hi_d = sign32(acc_q[63:32], neg_hi_q);
              lo_d = sign32(acc_q[31:0], neg_lo_q);
            end else begin
              {hi_d, lo_d} = sign64(acc_q, neg_lo_q);
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Control and architectural HI/LO state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      dzp_q   <= 1'b0;
      skip_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      dzp_q   <= dzp_d;
      skip_q  <= skip_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Iteration datapath
  always_ff @(posedge clk) begin
    acc_q    <= acc_d;
    bmag_q   <= bmag_d;
    isdiv_q  <= isdiv_d;
    neg_lo_q <= neg_lo_d;
    neg_hi_q <= neg_hi_d;
  end

  assign bus.hi       = hi_q;
  assign bus.lo       = lo_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_zero = dz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: transaction-level reference model plus directed literal vectors.
module tb_mul_div_unit;

`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif
  localparam int MUL_LAT = FAST_MUL ? 2 : 34;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul_div_unit_if bus();
  mul_div_unit dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result from plain arithmetic; HI:LO packed as {hi, lo}.
  function automatic logic [63:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = $signed({{32{a[31]}}, a});
    sb = $signed({{32{b[31]}}, b});
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (o)
      2'b00: return 64'(sa * sb);
      2'b01: return ua * ub;
      2'b10: begin q = sa / sb; r = sa % sb; return {r[31:0], q[31:0]}; end
      default: return {32'(ua % ub), 32'(ua / ub)};
    endcase
  endfunction

  // Model: cycles left until done, result applied when the count expires.
  int          m_left;
  logic [31:0] m_hi, m_lo;
  logic        m_done, m_dz, p_dz, p_wr;
  logic [63:0] p_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0; m_hi <= '0; m_lo <= '0; m_done <= 1'b0; m_dz <= 1'b0;
      p_dz <= 1'b0; p_wr <= 1'b0; p_res <= '0;
    end else begin
      m_done <= 1'b0;
      m_dz   <= 1'b0;
      if (m_left > 0) begin
        if (bus.flush) m_left <= 0;
        else begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_done <= 1'b1;
            m_dz   <= p_dz;
            if (p_wr) begin m_hi <= p_res[63:32]; m_lo <= p_res[31:0]; end
          end
        end
      end else if (bus.start) begin
        if (bus.op[1] && bus.operand_b == 32'd0) begin
          m_left <= 1; p_dz <= 1'b1; p_wr <= 1'b0;
        end else if (FAST_MUL && !bus.op[1]) begin
          {m_hi, m_lo} <= ref_res(bus.op, bus.operand_a, bus.operand_b);
          m_left <= 1; p_dz <= 1'b0; p_wr <= 1'b0;
        end else begin
          p_res  <= ref_res(bus.op, bus.operand_a, bus.operand_b);
          m_left <= 33; p_dz <= 1'b0; p_wr <= 1'b1;
        end
      end else begin
        if (bus.hi_we) m_hi <= bus.wdata;
        if (bus.lo_we) m_lo <= bus.wdata;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("cyc_busy", {63'd0, bus.busy}, {63'd0, (m_left != 0)});
      chk("cyc_done", {63'd0, bus.done}, {63'd0, m_done});
      chk("cyc_div_zero", {63'd0, bus.div_zero}, {63'd0, m_dz});
      chk("cyc_hi", {32'd0, bus.hi}, {32'd0, m_hi});
      chk("cyc_lo", {32'd0, bus.lo}, {32'd0, m_lo});
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_hi"}, {32'd0, bus.hi}, 64'd0);
    chk({tag, "_lo"}, {32'd0, bus.lo}, 64'd0);
    chk({tag, "_busy"}, {63'd0, bus.busy}, 64'd0);
    chk({tag, "_done"}, {63'd0, bus.done}, 64'd0);
    chk({tag, "_dz"}, {63'd0, bus.div_zero}, 64'd0);
  endtask

  // Start an op (now=1: in the current cycle, e.g. a done cycle), wait for done, check literals.
  task automatic do_op(input string name, input bit now, input logic [1:0] o,
                       input logic [31:0] a, input logic [31:0] b, input int exp_lat,
                       input logic [31:0] eh, input logic [31:0] el, input bit exp_dz);
    int lat;
    if (!now) @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.operand_a = a; bus.operand_b = b;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, 64'(lat), 64'(exp_lat));
    chk({name, "_hi"}, {32'd0, bus.hi}, {32'd0, eh});
    chk({name, "_lo"}, {32'd0, bus.lo}, {32'd0, el});
    chk({name, "_div_zero"}, {63'd0, bus.div_zero}, {63'd0, exp_dz});
  endtask

  typedef struct {
    logic [1:0]  o;
    logic [31:0] a, b, eh, el;
  } vec_t;

  vec_t vecs[5];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int cyc, dones;
    logic [31:0] sv_hi, sv_lo;
    bus.start = 1'b0; bus.op = 2'b00; bus.operand_a = '0; bus.operand_b = '0;
    bus.flush = 1'b0; bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    chk_en = 1'b1;

    do_op("mult_neg", 1'b0, 2'b00, 32'hFFFFFFFD, 32'd5, MUL_LAT, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0);
    do_op("multu_max", 1'b0, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    do_op("div_m7_2", 1'b0, 2'b10, 32'hFFFFFFF9, 32'd2, 34, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    do_op("div_ovf_b2b", 1'b1, 2'b10, 32'h80000000, 32'hFFFFFFFF, 34, 32'h0, 32'h80000000, 1'b0);

    @(negedge clk);
    bus.lo_we = 1'b1; bus.wdata = 32'h1234;
    @(negedge clk);
    bus.lo_we = 1'b0;
    chk("mtlo", {32'd0, bus.lo}, 64'h1234);
    do_op("divu_zero", 1'b0, 2'b11, 32'd99, 32'd0, 2, 32'h0, 32'h1234, 1'b1);

    @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("idle_flush_lo", {32'd0, bus.lo}, 64'h1234);

    // Flush in cycle 10, with an ignored MTHI while busy.
    sv_hi = bus.hi; sv_lo = bus.lo;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b11; bus.operand_a = 32'd100; bus.operand_b = 32'd7;
    for (cyc = 1; cyc <= 11; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.hi_we = (cyc == 5);
      bus.wdata = 32'hDEAD0000;
      bus.flush = (cyc == 10);
    end
    chk("flush_busy_c11", {63'd0, bus.busy}, 64'd0);
    dones = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    chk("flush_no_done", 64'(dones), 64'd0);
    chk("flush_hi", {32'd0, bus.hi}, {32'd0, sv_hi});
    chk("flush_lo", {32'd0, bus.lo}, {32'd0, sv_lo});

    // Restart attempt in cycle 20 of a busy DIVU must be ignored.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b11; bus.operand_a = 32'd100; bus.operand_b = 32'd7;
    cyc = 0;
    while (cyc < 60) begin
      @(negedge clk);
      cyc++;
      bus.start = (cyc == 20);
      if (cyc == 20) begin bus.operand_a = 32'd1000; bus.operand_b = 32'd3; end
      if (bus.done) break;
    end
    bus.start = 1'b0;
    chk("ignored_start_lat", 64'(cyc), 64'd34);
    chk("ignored_start_lo", {32'd0, bus.lo}, 64'd14);
    chk("ignored_start_hi", {32'd0, bus.hi}, 64'd2);

    vecs[0] = '{2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD};
    vecs[1] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0};
    vecs[2] = '{2'b11, 32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF};
    vecs[3] = '{2'b01, 32'h10000, 32'h10000, 32'd1, 32'd0};
    vecs[4] = '{2'b10, 32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'd2};
    foreach (vecs[i])
      do_op($sformatf("vec%0d", i), 1'b0, vecs[i].o, vecs[i].a, vecs[i].b,
            vecs[i].o[1] ? 34 : MUL_LAT, vecs[i].eh, vecs[i].el, 1'b0);

    // Reset pulse in cycle 15 of a MULT.
    @(negedge clk);
    bus.start = 1'b1; bus.op = 2'b00; bus.operand_a = 32'h12345678; bus.operand_b = 32'd3;
    repeat (15) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midop_reset");
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    chk("reset_no_done", 64'(dones), 64'd0);

    // MTHI in the done cycle.
    do_op("mult_small", 1'b0, 2'b00, 32'd3, 32'd4, MUL_LAT, 32'd0, 32'd12, 1'b0);
    bus.hi_we = 1'b1; bus.wdata = 32'hA5A5A5A5;
    @(negedge clk);
    bus.hi_we = 1'b0;
    chk("mthi_done_cycle_hi", {32'd0, bus.hi}, 64'hA5A5A5A5);
    chk("mthi_done_cycle_lo", {32'd0, bus.lo}, 64'd12);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have ports: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-002 SHALL have ports: start input 1, begin an operation; op input 2, 00=MULT, 01=MULTU, 10=DIV, 11=DIVU; operand_a input 32, forwarded rs value (dividend); operand_b input 32, forwarded rt value (divisor).
REQ-003 SHALL have ports: flush input 1, abort the in-flight operation; hi_we input 1, MTHI write; lo_we input 1, MTLO write; wdata input 32, MTHI/MTLO data.
REQ-004 SHALL have ports: hi output 32, HI register; lo output 32, LO register; busy output 1, operation in flight (pipeline stall request); done output 1, one-cycle completion pulse; div_zero output 1, one-cycle pulse with done on a zero divisor.

Function
REQ-005 SHALL implement FSM states IDLE, CALC, SIGN; busy=1 in CALC and SIGN, 0 in IDLE.
REQ-006 SHALL accept start only in IDLE; it latches op, the operand magnitudes (absolute values for MULT/DIV, raw for MULTU/DIVU), the result sign bits, and a 5-bit iteration counter cleared to 0, then enters CALC.
REQ-007 SHALL ignore start while busy=1.
REQ-008 SHALL iterate for exactly 32 CALC cycles: multiply uses radix-2 shift-add into a 64-bit accumulator; divide uses restoring division, one quotient bit per cycle.
REQ-009 SHALL pass CALC->SIGN when the counter wraps from 31; in SIGN it negates the results as required, writes HI/LO, and returns to IDLE.
REQ-010 SHALL write {HI,LO} with the 64-bit product for multiply, and LO=quotient, HI=remainder for divide.
REQ-011 SHALL give the quotient sign a XOR b and the remainder the dividend's sign for DIV; results are truncated to 32 bits, so 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
REQ-012 SHALL assert done for exactly one cycle, the cycle after SIGN; with start accepted in cycle 0, done=1 in cycle 34 and busy=1 in cycles 1-33.
REQ-013 SHALL, for a DIV/DIVU with operand_b=0 at start, skip CALC, leave HI/LO unchanged, and pulse done and div_zero in cycle 2 (busy=1 in cycle 1 only).
REQ-014 SHALL, on flush while busy, return to IDLE at the next edge with HI/LO unchanged and no done; flush in IDLE has no effect.
REQ-015 SHALL apply hi_we/lo_we writes only in IDLE with start=0; a start in the same cycle wins and drops the write; writes while busy are ignored.
REQ-016 SHALL allow a new start in the same cycle that done=1.
REQ-017 SHALL drive hi, lo, busy, done and div_zero directly from registers.

Reset
REQ-018 SHALL, while rst_n=0, asynchronously force state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0, div_zero=0.
REQ-019 SHALL discard any in-flight operation on reset mid-operation; no done follows after release.

Configuration
REQ-020 SHALL, with macro MULDIV_FAST_MUL_EN defined, compute MULT/MULTU as a single-cycle 64-bit product written to HI/LO at the first edge after start, with done=1 in cycle 2 and busy=1 in cycle 1.
REQ-021 SHALL, without MULDIV_FAST_MUL_EN, use the 32-iteration path for multiply; divide timing is identical in both builds.

Verification
REQ-022 SHALL cover: MULT a=0xFFFFFFFD, b=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFF1, done in cycle 34 (cycle 2 with MULDIV_FAST_MUL_EN).
REQ-023 SHALL cover: MULTU a=b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
REQ-024 SHALL cover: DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; then DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-025 SHALL cover: MTLO 0x1234 then DIVU b=0 -> done=div_zero=1 in cycle 2, LO=0x1234 unchanged.
REQ-026 SHALL cover: DIVU started, flush in cycle 10 -> busy=0 in cycle 11, no done, HI/LO unchanged; start repeated in cycle 20 during a busy op is ignored.
REQ-027 SHALL cover: rst_n pulsed low in cycle 15 of a MULT -> all outputs 0 immediately, no done afterward; MTHI 0xA5A5A5A5 in the cycle done=1 with start=0 -> hi=0xA5A5A5A5.
